mem_access_ctrl: RTL and testbench

Initiator-side controller for the byte-addressed, big-endian word memory used in the ARM pipeline. It sits in the MEM stage between the EXE/MEM pipeline register and the memory. It turns LDR/STR requests into correctly sequenced memory strobes with a programmable number of wait cycles, and freezes the pipeline until each access completes. It also word-aligns every address and flags misaligned and out-of-range accesses.

---
 rtl/mem_access_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator for the word memory: sequences LDR/STR strobes with a
// fixed wait count, freezes the pipeline while busy, and flags bad addresses.
module mem_access_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int MEM_SIZE    = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              freeze,
    output logic              err_misaligned,
    output logic              err_range,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [3:0]      CNT_INIT  = 4'(WAIT_CYCLES - 1);
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_SIZE);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_mis_q, err_mis_d;
    logic                err_rng_q, err_rng_d;

    logic [ADDR_W-1:0]   req_aligned;
    logic                req_oor;

    // Range test is done one bit wider so addresses near the top cannot wrap.
    assign req_aligned = {req_addr[ADDR_W-1:2], 2'b00};
    assign req_oor     = ({1'b0, req_aligned} + (ADDR_W + 1)'(3)) >= MEM_LIMIT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_mis_q <= 1'b0;
            err_rng_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_mis_q <= err_mis_d;
            err_rng_q <= err_rng_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_mis_d = err_mis_q;
        err_rng_d = err_rng_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_aligned;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    if (req_addr[1:0] != 2'b00) begin
                        err_mis_d = 1'b1;
                    end
                    if (req_oor) begin
                        err_rng_d = 1'b1;
                        state_d   = RESP;
                        if (!req_write) begin
                            rdata_d = '0;
                        end
                    end else begin
                        state_d = req_write ? WRITE : READ;
                    end
                end
            end
            READ: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = mem_read_data;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WRITE: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode from registered state so an async reset drops them at once.
    always_comb begin
        req_ready      = (state_q == IDLE);
        resp_valid     = (state_q == RESP);
        mem_read       = (state_q == READ);
        mem_write      = (state_q == WRITE) && (cnt_q == CNT_INIT);
        freeze         = (state_q == READ) || (state_q == WRITE) ||
                         ((state_q == IDLE) && req_valid);
        mem_addr       = addr_q;
        mem_write_data = wdata_q;
        resp_rdata     = rdata_q;
        err_misaligned = err_mis_q;
        err_range      = err_rng_q;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a transaction-level model predicts every output
// each cycle, alongside directed accesses with hand-derived expectations.
module tb_mem_access_ctrl;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, freeze, err_misaligned, err_range;
    logic [31:0] resp_rdata, mem_addr, mem_write_data, mem_read_data;
    logic        mem_read, mem_write;

    int checks = 0;
    int failures = 0;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W), .MEM_SIZE(256)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .freeze(freeze), .err_misaligned(err_misaligned), .err_range(err_range),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT
    logic [31:0] mem [64];
    initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_write_data;
    assign mem_read_data = mem[mem_addr[7:2]];

    // Model: m_k counts cycles since acceptance (0 = idle), m_len is the cycle of resp_valid
    logic [31:0] m_mem [64];
    initial for (int i = 0; i < 64; i++) m_mem[i] = 32'h0;
    int          m_k = 0;
    int          m_len = 1;
    logic        m_wr;
    logic [31:0] m_rdata, m_maddr, m_mwdata;
    logic        m_mis, m_rng;

    wire [31:0] req_al  = {req_addr[31:2], 2'b00};
    wire        req_oor = ({1'b0, req_al} + 33'd3) >= 33'd256;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k <= 0; m_len <= 1; m_wr <= 1'b0; m_rdata <= '0;
            m_maddr <= '0; m_mwdata <= '0; m_mis <= 1'b0; m_rng <= 1'b0;
        end else if (m_k == 0) begin
            if (req_valid) begin
                m_k      <= 1;
                m_len    <= req_oor ? 1 : W + 1;
                m_wr     <= req_write;
                m_maddr  <= req_al;
                m_mwdata <= req_wdata;
                m_mis    <= m_mis | (req_addr[1:0] != 2'b00);
                m_rng    <= m_rng | req_oor;
                if (req_oor && !req_write) m_rdata <= '0;
            end
        end else if (m_k == m_len) begin
            m_k <= 0;
        end else begin
            m_k <= m_k + 1;
            if (m_wr && m_k == 1) m_mem[m_maddr[7:2]] <= m_mwdata;
            if (!m_wr && m_k == W) m_rdata <= m_mem[m_maddr[7:2]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("req_ready",      32'(req_ready),      32'(m_k == 0));
            chk("resp_valid",     32'(resp_valid),     32'(m_k != 0 && m_k == m_len));
            chk("freeze",         32'(freeze),         32'((m_k == 0) ? req_valid : (m_k != m_len)));
            chk("mem_read",       32'(mem_read),       32'(m_k != 0 && m_k != m_len && !m_wr));
            chk("mem_write",      32'(mem_write),      32'(m_k == 1 && m_k != m_len && m_wr));
            chk("mem_addr",       mem_addr,            m_maddr);
            chk("mem_write_data", mem_write_data,      m_mwdata);
            chk("resp_rdata",     resp_rdata,          m_rdata);
            chk("err_misaligned", 32'(err_misaligned), 32'(m_mis));
            chk("err_range",      32'(err_range),      32'(m_rng));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request at cycle 0; reports strobes/address seen in cycle 1.
    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic hold_junk, input int exp_lat,
                          input logic chk_rd, input logic [31:0] exp_rd,
                          output logic s1, output logic [31:0] a1);
        int lat;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        tick();
        s1 = mem_read | mem_write;
        a1 = mem_addr;
        if (hold_junk) begin
            req_write = 1'b1; req_addr = 32'h80; req_wdata = 32'hDEADBEEF;
        end else begin
            req_valid = 1'b0;
        end
        lat = 1;
        while (!resp_valid && lat < 12) begin
            tick();
            lat++;
        end
        req_valid = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
        if (chk_rd) chk("load_data", resp_rdata, exp_rd);
        tick();
    endtask

    logic        s1;
    logic [31:0] a1;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_freeze",    32'(freeze),    32'd0);
        chk("rst_strobes",   32'(mem_read | mem_write | resp_valid), 32'd0);
        chk("rst_rdata",     resp_rdata,     32'd0);
        chk("rst_errs",      32'({err_misaligned, err_range}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        tick(); tick();

        access(1'b1, 32'h40, 32'h00002000, 1'b0, 3, 1'b0, '0, s1, a1);
        chk("st40_c1_strobe", 32'(s1), 32'd1);
        chk("st40_c1_addr",   a1,       32'h40);
        access(1'b0, 32'h40, '0, 1'b0, 3, 1'b1, 32'h00002000, s1, a1);
        access(1'b1, 32'h44, 32'hC0000000, 1'b1, 3, 1'b0, '0, s1, a1);
        access(1'b0, 32'h44, '0, 1'b0, 3, 1'b1, 32'hC0000000, s1, a1);
        access(1'b0, 32'h43, '0, 1'b0, 3, 1'b1, 32'h00002000, s1, a1);
        chk("mis_addr", a1, 32'h40);
        chk("mis_flag", 32'(err_misaligned), 32'd1);
        access(1'b1, 32'h48, 32'h12345678, 1'b0, 3, 1'b0, '0, s1, a1);
        chk("mis_sticky", 32'(err_misaligned), 32'd1);
        access(1'b0, 32'h100, '0, 1'b0, 1, 1'b1, 32'h0, s1, a1);
        chk("oor_no_strobe", 32'(s1), 32'd0);
        chk("oor_flag", 32'(err_range), 32'd1);
        access(1'b1, 32'hFC, 32'hA5A5_0F0F, 1'b0, 3, 1'b0, '0, s1, a1);
        access(1'b0, 32'hFD, '0, 1'b0, 3, 1'b1, 32'hA5A5_0F0F, s1, a1);
        chk("top_word_addr", a1, 32'hFC);
        chk("oor_sticky", 32'(err_range), 32'd1);

        // Async reset during the first READ cycle
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40;
        tick();
        req_valid = 1'b0;
        chk("pre_rst_read", 32'(mem_read), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_read_drop", 32'(mem_read), 32'd0);
        chk("rst_ready",     32'(req_ready), 32'd1);
        chk("rst_flags_clr", 32'({err_misaligned, err_range}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_resp_after_rst", 32'(resp_valid), 32'd0);
        end
        access(1'b0, 32'h44, '0, 1'b0, 3, 1'b1, 32'hC0000000, s1, a1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
